// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, CPSR bit indices and sequencer state encoding
//
// Purpose : constants and types for the execute-stage sequencer and the
//           opcode decoder, so any future decoder uses the same encodings.
// Ports   : none (package)
package alu_pkg;

  // 6-bit instruction opcodes
  localparam logic [5:0] OP_ADD = 6'b000110;
  localparam logic [5:0] OP_SUB = 6'b001001;
  localparam logic [5:0] OP_AND = 6'b001011;
  localparam logic [5:0] OP_OR  = 6'b001010;
  localparam logic [5:0] OP_NOT = 6'b001100;
  localparam logic [5:0] OP_XOR = 6'b001110;
  localparam logic [5:0] OP_CMP = 6'b011101;
  localparam logic [5:0] OP_MOV = 6'b011100;
  localparam logic [5:0] OP_BEQ = 6'b100100;

  // CPSR bit positions within the 4-bit flag word
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_WB      = 2'd2,
    ST_BR_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational opcode classifier
//
// Purpose : classifies a 6-bit opcode for the execute sequencer.
// Ports   : opcode     in  6  opcode to classify
//           is_data    out 1  produces a result for writeback
//           sets_flags out 1  may update CPSR (still gated by the S bit)
//           is_beq     out 1  conditional branch on Z
//           is_illegal out 1  not a recognised opcode
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       is_data,
  output logic       sets_flags,
  output logic       is_beq,
  output logic       is_illegal
);

  always_comb begin
    is_data    = 1'b0;
    sets_flags = 1'b0;
    is_beq     = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_CMP: begin
        is_data    = 1'b1;
        sets_flags = 1'b1;
      end
      OP_AND, OP_OR, OP_NOT, OP_XOR, OP_MOV: begin
        is_data = 1'b1;
      end
      OP_BEQ: begin
        is_beq = 1'b1;
      end
      default: begin
        is_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - execute-stage sequencer around a combinational ALU
//
// Purpose : accepts one instruction at a time, holds the ALU operands for
//           ALU_LAT cycles, samples the result, owns the CPSR flag register
//           and turns BEQ into a cycle-counted br_taken pulse.
// Ports   : clk, reset                  clock, synchronous active-high reset
//           issue_valid/issue_ready     instruction handshake
//           issue_opcode/a/b/s/pc_br    instruction fields
//           alu_opcode/a/b/s/pc_br      held operands to the external ALU
//           alu_result, alu_cpsr        ALU outputs (cpsr = N,Z,C,V)
//           wb_valid/wb_ready/wb_result writeback handshake and data
//           flags                       architectural CPSR
//           br_taken, br_target         taken-BEQ pulse and its target
//           illegal_op                  one-cycle unrecognised-opcode pulse
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LAT         = 1,
  parameter int unsigned BR_PULSE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [5:0]  issue_opcode,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  input  logic        issue_s,
  input  logic [23:0] issue_pc_br,
  output logic [5:0]  alu_opcode,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_s,
  output logic [23:0] alu_pc_br,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_cpsr,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_result,
  output logic [3:0]  flags,
  output logic        br_taken,
  output logic [23:0] br_target,
  output logic        illegal_op
);

  // Counters reload with N-1 so that the terminal edge is the one seen at 0.
  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);
  localparam logic [3:0] BR_INIT  = 4'(BR_PULSE_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] lat_cnt;
  logic [3:0] br_cnt;

  logic dec_data;
  logic dec_flags;
  logic dec_beq;
  logic dec_illegal;

  logic accept;
  logic exec_done;
  logic beq_taken;
  logic wb_done;

  // Decode the held opcode, not the issue port, so dispatch sees the
  // instruction that is actually in flight.
  alu_op_decode u_decode (
    .opcode     (alu_opcode),
    .is_data    (dec_data),
    .sets_flags (dec_flags),
    .is_beq     (dec_beq),
    .is_illegal (dec_illegal)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (issue_valid) begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (lat_cnt == 4'd0) begin
          if (dec_data) begin
            state_next = ST_WB;
          end else if (dec_beq && flags[FLAG_Z]) begin
            state_next = ST_BR_HOLD;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_WB: begin
        if (wb_ready) begin
          state_next = ST_IDLE;
        end
      end
      ST_BR_HOLD: begin
        if (br_cnt == 4'd0) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output / strobe decode
  always_comb begin
    issue_ready = (state == ST_IDLE);
    accept      = (state == ST_IDLE) && issue_valid;
    exec_done   = (state == ST_EXEC) && (lat_cnt == 4'd0);
    beq_taken   = exec_done && dec_beq && flags[FLAG_Z];
    wb_done     = (state == ST_WB) && wb_ready;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_opcode <= 6'd0;
      alu_a      <= 32'd0;
      alu_b      <= 32'd0;
      alu_s      <= 1'b0;
      alu_pc_br  <= 24'd0;
      lat_cnt    <= 4'd0;
      br_cnt     <= 4'd0;
      wb_valid   <= 1'b0;
      wb_result  <= 32'd0;
      flags      <= 4'd0;
      br_taken   <= 1'b0;
      br_target  <= 24'd0;
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= 1'b0;

      if (accept) begin
        alu_opcode <= issue_opcode;
        alu_a      <= issue_a;
        alu_b      <= issue_b;
        alu_s      <= issue_s;
        alu_pc_br  <= issue_pc_br;
        lat_cnt    <= LAT_INIT;
      end

      if ((state == ST_EXEC) && (lat_cnt != 4'd0)) begin
        lat_cnt <= lat_cnt - 4'd1;
      end

      if (exec_done) begin
        if (dec_data) begin
          wb_result <= alu_result;
          wb_valid  <= 1'b1;
        end
        // Flags land on the dispatch edge, before IDLE can accept the next
        // instruction, so a following BEQ always sees the new Z.
        if (dec_flags && alu_s) begin
          flags <= alu_cpsr;
        end
        if (dec_illegal) begin
          illegal_op <= 1'b1;
        end
      end

      if (beq_taken) begin
        br_taken  <= 1'b1;
        br_target <= alu_pc_br;
        br_cnt    <= BR_INIT;
      end

      if (wb_done) begin
        wb_valid <= 1'b0;
      end

      // br_target is deliberately left holding after the pulse ends.
      if (state == ST_BR_HOLD) begin
        if (br_cnt == 4'd0) begin
          br_taken <= 1'b0;
        end else begin
          br_cnt <= br_cnt - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb/tb_alu_exec_ctrl.sv - scoreboard bench for alu_exec_ctrl
module tb_alu_exec_ctrl;
  import alu_pkg::*;

  localparam int ALU_LAT  = 3;
  localparam int BR_PULSE = 4;

  localparam int K_WB   = 0;
  localparam int K_BR   = 1;
  localparam int K_ILL  = 2;
  localparam int K_NONE = 3;

  localparam logic [5:0] OP_BAD = 6'b111111;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  issue_opcode;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic        issue_s;
  logic [23:0] issue_pc_br;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_s;
  logic [23:0] alu_pc_br;
  logic [31:0] alu_result;
  logic [3:0]  alu_cpsr;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_result;
  logic [3:0]  flags;
  logic        br_taken;
  logic [23:0] br_target;
  logic        illegal_op;

  always #5 clk = ~clk;

  alu_exec_ctrl #(
    .ALU_LAT         (ALU_LAT),
    .BR_PULSE_CYCLES (BR_PULSE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_opcode (issue_opcode),
    .issue_a      (issue_a),
    .issue_b      (issue_b),
    .issue_s      (issue_s),
    .issue_pc_br  (issue_pc_br),
    .alu_opcode   (alu_opcode),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_s        (alu_s),
    .alu_pc_br    (alu_pc_br),
    .alu_result   (alu_result),
    .alu_cpsr     (alu_cpsr),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_result    (wb_result),
    .flags        (flags),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .illegal_op   (illegal_op)
  );

  // Stand-in for the external combinational ALU
  logic [32:0] m_sum;
  logic [31:0] m_r;
  logic        m_c;
  logic        m_v;
  always_comb begin
    m_sum = 33'd0;
    m_r   = 32'd0;
    m_c   = 1'b0;
    m_v   = 1'b0;
    case (alu_opcode)
      OP_ADD: begin
        m_sum = {1'b0, alu_a} + {1'b0, alu_b};
        m_r   = m_sum[31:0];
        m_c   = m_sum[32];
        m_v   = (alu_a[31] == alu_b[31]) && (m_r[31] != alu_a[31]);
      end
      OP_SUB, OP_CMP: begin
        m_r = alu_a - alu_b;
        m_c = (alu_a >= alu_b);
        m_v = (alu_a[31] != alu_b[31]) && (m_r[31] != alu_a[31]);
      end
      OP_AND: m_r = alu_a & alu_b;
      OP_OR:  m_r = alu_a | alu_b;
      OP_XOR: m_r = alu_a ^ alu_b;
      OP_NOT: m_r = ~alu_a;
      OP_MOV: m_r = alu_b;
      default: m_r = 32'd0;
    endcase
    alu_result = m_r;
    alu_cpsr   = {m_r[31], (m_r == 32'd0), m_c, m_v};
  end

  typedef struct {
    int          kind;
    logic [31:0] res;
    logic [3:0]  fl;
    logic [23:0] tgt;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT raises an output event
  logic        prev_wb = 1'b0;
  logic        prev_br = 1'b0;
  logic        prev_ill = 1'b0;
  int          br_len = 0;
  int          ill_len = 0;
  logic [31:0] cur_res = 32'd0;
  logic [23:0] cur_tgt = 24'd0;

  task automatic pop_check(input int kind, input string name, input logic [31:0] res, input logic [23:0] tgt);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected actual=event expected=none", name);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_kind"}, 64'(kind), 64'(e.kind));
      chk({name, "_flags"}, 64'(flags), 64'(e.fl));
      chk({name, "_cycle"}, 64'(cyc), 64'(e.cyc));
      if (e.kind == K_WB) begin
        chk({name, "_result"}, 64'(res), 64'(e.res));
        cur_res = e.res;
      end
      if (e.kind == K_BR) begin
        chk({name, "_target"}, 64'(tgt), 64'(e.tgt));
        cur_tgt = e.tgt;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (wb_valid && !prev_wb) pop_check(K_WB, "wb", wb_result, 24'd0);
      else if (wb_valid && prev_wb) chk("wb_hold", 64'(wb_result), 64'(cur_res));

      if (br_taken && !prev_br) begin
        pop_check(K_BR, "br", 32'd0, br_target);
        br_len = 1;
      end else if (br_taken && prev_br) begin
        br_len++;
      end else if (!br_taken && prev_br) begin
        chk("br_width", 64'(br_len), 64'(BR_PULSE));
        chk("br_target_hold", 64'(br_target), 64'(cur_tgt));
      end

      if (illegal_op && !prev_ill) begin
        pop_check(K_ILL, "ill", 32'd0, 24'd0);
        ill_len = 1;
      end else if (illegal_op && prev_ill) begin
        ill_len++;
      end else if (!illegal_op && prev_ill) begin
        chk("ill_width", 64'(ill_len), 64'd1);
      end
    end
    prev_wb  = wb_valid;
    prev_br  = br_taken;
    prev_ill = illegal_op;
  end

  task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic [23:0] pc, input int kind,
                      input logic [31:0] res, input logic [3:0] fl);
    int n = 0;
    ev_t e;
    @(negedge clk);
    while (!issue_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!issue_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout actual=not_ready expected=ready");
    end
    issue_opcode = op;
    issue_a      = a;
    issue_b      = b;
    issue_s      = s;
    issue_pc_br  = pc;
    issue_valid  = 1'b1;
    if (kind != K_NONE) begin
      e.kind = kind;
      e.res  = res;
      e.fl   = fl;
      e.tgt  = pc;
      e.cyc  = cyc + 1 + ALU_LAT;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    // Junk on the issue port must not disturb the held operands.
    issue_opcode = OP_ADD;
    issue_a      = 32'hDEADBEEF;
    issue_b      = 32'hCAFEF00D;
    issue_s      = 1'b1;
    issue_pc_br  = 24'hFFFFFF;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !issue_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || !issue_ready) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=pending%0d expected=pending0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int n;
    reset        = 1'b1;
    issue_valid  = 1'b0;
    issue_opcode = 6'd0;
    issue_a      = 32'd0;
    issue_b      = 32'd0;
    issue_s      = 1'b0;
    issue_pc_br  = 24'd0;
    wb_ready     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_issue_ready", 64'(issue_ready), 64'd1);
    chk("rst_status", 64'({wb_valid, br_taken, illegal_op, flags, br_target}), 64'd0);
    chk("rst_alu", 64'({alu_opcode, alu_s, alu_pc_br}), 64'd0);
    chk("rst_alu_ab", {alu_a, alu_b}, 64'd0);
    chk("rst_wb_result", 64'(wb_result), 64'd0);
    reset = 1'b0;

    // Reset in the 2nd EXEC cycle of a flag-setting ADD aborts it
    send(OP_ADD, 32'hFFFFFFFF, 32'd1, 1'b1, 24'd0, K_NONE, 32'd0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_status", 64'({wb_valid, br_taken, illegal_op, flags}), 64'd0);
    chk("abort_alu", {alu_a, alu_b}, 64'd0);
    chk("abort_ready", 64'(issue_ready), 64'd1);
    repeat (ALU_LAT + 3) @(negedge clk);
    chk("abort_flags_later", 64'({wb_valid, flags}), 64'd0);

    // Data op, flag update, taken BEQ
    send(OP_ADD, 32'd5, 32'd3, 1'b1, 24'd0, K_WB, 32'd8, 4'b0000);
    send(OP_SUB, 32'd7, 32'd7, 1'b1, 24'd0, K_WB, 32'd0, 4'b0110);
    send(OP_BEQ, 32'd0, 32'd0, 1'b0, 24'h000123, K_BR, 32'd0, 4'b0110);
    wait_idle();
    chk("flags_after_beq", 64'(flags), 64'b0110);

    // Z retained across a non-S SUB
    send(OP_SUB, 32'd9, 32'd2, 1'b0, 24'd0, K_WB, 32'd7, 4'b0110);
    send(OP_BEQ, 32'd0, 32'd0, 1'b1, 24'h000456, K_BR, 32'd0, 4'b0110);
    wait_idle();

    // From reset, a non-S SUB leaves Z clear: BEQ not taken
    do_reset();
    send(OP_SUB, 32'd7, 32'd7, 1'b0, 24'd0, K_WB, 32'd0, 4'b0000);
    send(OP_BEQ, 32'd0, 32'd0, 1'b0, 24'h000789, K_NONE, 32'd0, 4'd0);
    repeat (ALU_LAT + 2) @(negedge clk);
    chk("beq_not_taken", 64'({br_taken, br_target}), 64'd0);
    wait_idle();

    // Overflow: N and V set
    send(OP_ADD, 32'h7FFFFFFF, 32'd1, 1'b1, 24'd0, K_WB, 32'h80000000, 4'b1001);

    // Writeback stall: held result, no issue accepted
    wait_idle();
    wb_ready = 1'b0;
    send(OP_AND, 32'hFF00FF00, 32'h0F0F0F0F, 1'b1, 24'd0, K_WB, 32'h0F000F00, 4'b1001);
    n = 0;
    while (!wb_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    issue_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_wb", 64'({issue_ready, wb_valid, wb_result}), {31'd0, 1'b0, 1'b1, 32'h0F000F00});
      @(negedge clk);
    end
    issue_valid = 1'b0;
    wb_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release", 64'({wb_valid, issue_ready}), 64'b01);

    // Illegal opcode with S set: no flag change, next issue accepted
    send(OP_BAD, 32'd1, 32'd1, 1'b1, 24'h00ABCD, K_ILL, 32'd0, 4'b1001);
    send(OP_CMP, 32'd3, 32'd5, 1'b1, 24'd0, K_WB, 32'hFFFFFFFE, 4'b1000);
    send(OP_OR, 32'h000000F0, 32'h0000000F, 1'b1, 24'd0, K_WB, 32'h000000FF, 4'b1000);
    send(OP_XOR, 32'hAAAA5555, 32'hFFFF0000, 1'b0, 24'd0, K_WB, 32'h55555555, 4'b1000);
    send(OP_NOT, 32'h0000FFFF, 32'd0, 1'b1, 24'd0, K_WB, 32'hFFFF0000, 4'b1000);
    send(OP_MOV, 32'd0, 32'h12345678, 1'b1, 24'd0, K_WB, 32'h12345678, 4'b1000);
    send(OP_BEQ, 32'd0, 32'd0, 1'b1, 24'h000AAA, K_NONE, 32'd0, 4'd0);
    repeat (ALU_LAT + 2) @(negedge clk);
    chk("beq_z0_flags", 64'({br_taken, flags}), 64'b01000);

    // Carry-out to zero sets Z and C; branch taken again
    send(OP_ADD, 32'hFFFFFFFF, 32'd1, 1'b1, 24'd0, K_WB, 32'd0, 4'b0110);
    send(OP_BEQ, 32'd0, 32'd0, 1'b0, 24'hABCDEF, K_BR, 32'd0, 4'b0110);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("end_target_hold", 64'(br_target), 64'hABCDEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
